// File: rtl/prog_cnt_pkg.sv
// Shared encodings for the programmable counter: count modes and control FSM states.
package prog_cnt_pkg;

  // Terminal-event behaviour; the spare encoding behaves like WRAP
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Control FSM: IDLE (stopped), RUN (counting ticks), DONE (one-shot finished)
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/prog_cnt_prescaler.sv
// Prescaler for prog_counter: counts clock cycles and emits a tick every presc+1
// cycles while not held. Held (and cleared) whenever the counter is not actively
// running, so a fresh run always waits a full presc+1 cycles for its first tick.
module prog_cnt_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clki,
  input  logic                  rstn_n,
  input  logic [PRESCALE_W-1:0] presc,
  input  logic                  hold,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_pcnt;

  // Exact compare: a presc below the current pcnt lets pcnt run on and wrap first
  assign tick = !hold && (r_pcnt == presc);

  // Cycle counter: cleared on hold or tick, otherwise free-running modulo 2^PRESCALE_W
  always_ff @(posedge clki or negedge rstn_n) begin
    if (!rstn_n) begin
      r_pcnt <= '0;
    end else if (hold || tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PCNT_ONE;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable counter: prescaled ticks, up/down, modulus, parallel load and
// WRAP / SAT / ONESHOT terminal behaviour, with tc pulse, sticky ovf and busy.
// Optional capture port set (cap, cap_val, cap_vld) enabled by PROG_CNT_CAPTURE_EN.
module prog_counter
  import prog_cnt_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clki,
  input  logic                  rstn_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [PRESCALE_W-1:0] presc,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  busy
`ifdef PROG_CNT_CAPTURE_EN
  ,
  input  logic                  cap,
  output logic [WIDTH-1:0]      cap_val,
  output logic                  cap_vld
`endif
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_count, w_count_next;
  logic             r_tc, w_tc_next;
  logic             r_ovf, w_ovf_next;
  logic             r_busy;
  logic             w_run_active;
  logic             w_tick;
  logic             w_terminal;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  // Only a plain RUN cycle advances the prescaler; clr, load or en=0 hold it at 0
  assign w_run_active = (r_state == RUN) && en && !clr && !load;

  // Up count ends at or beyond modulus (so modulus=0 ends on every tick); down ends at 0
  assign w_terminal = dir ? (r_count >= modulus) : (r_count == '0);

  prog_cnt_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clki  (clki),
    .rstn_n(rstn_n),
    .presc (presc),
    .hold  (!w_run_active),
    .tick  (w_tick)
  );

  // Next state and datapath: clr beats load beats tick step
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    w_ovf_next   = r_ovf;

    if (clr) begin
      w_state_next = IDLE;
      w_count_next = '0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (en) w_state_next = RUN;
        RUN:     if (!en) w_state_next = IDLE;
        DONE:    if (load && en) w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase

      if (load) begin
        w_count_next = load_val;
      end else if (w_tick) begin
        if (!w_terminal) begin
          w_count_next = dir ? (r_count + CNT_ONE) : (r_count - CNT_ONE);
        end else begin
          case (w_mode)
            MODE_SAT: begin
              // Saturation reports only the first terminal event since ovf was cleared
              w_tc_next  = !r_ovf;
              w_ovf_next = 1'b1;
            end
            MODE_ONESHOT: begin
              w_tc_next    = 1'b1;
              w_ovf_next   = 1'b1;
              w_state_next = DONE;
            end
            default: begin
              w_count_next = dir ? '0 : modulus;
              w_tc_next    = 1'b1;
              w_ovf_next   = 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Register state and all outputs so tc lines up with the post-event count
  always_ff @(posedge clki or negedge rstn_n) begin
    if (!rstn_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
      r_ovf   <= w_ovf_next;
      r_busy  <= (w_state_next == RUN);
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign busy  = r_busy;

`ifdef PROG_CNT_CAPTURE_EN
  logic [WIDTH-1:0] r_cap_val;
  logic             r_cap_vld;

  // Snapshot the count as it stood before this cycle's update; clr leaves it alone
  always_ff @(posedge clki or negedge rstn_n) begin
    if (!rstn_n) begin
      r_cap_val <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= cap;
      if (cap) r_cap_val <= r_count;
    end
  end

  assign cap_val = r_cap_val;
  assign cap_vld = r_cap_vld;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Testbench for prog_counter: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model written from the counter's rules.
module tb_prog_counter;

  localparam int W    = 8;
  localparam int PW   = 4;
  localparam int MAXV = 1 << W;
  localparam int PMAX = 1 << PW;

  logic          clki = 1'b0;
  logic          rstn_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          dir = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  modulus = '0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  count;
  logic          tc;
  logic          ovf;
  logic          busy;
`ifdef PROG_CNT_CAPTURE_EN
  logic          cap = 1'b0;
  logic [W-1:0]  cap_val;
  logic          cap_vld;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state (m_st: 0 stopped, 1 running, 2 one-shot finished)
  int   m_count, m_pcnt, m_st;
  logic m_tc, m_ovf;
`ifdef PROG_CNT_CAPTURE_EN
  int   m_cap_val;
  logic m_cap_vld;
`endif

  prog_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clki    (clki),
    .rstn_n  (rstn_n),
    .en      (en),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .dir     (dir),
    .mode    (mode),
    .modulus (modulus),
    .presc   (presc),
    .count   (count),
    .tc      (tc),
    .ovf     (ovf),
    .busy    (busy)
`ifdef PROG_CNT_CAPTURE_EN
    ,
    .cap     (cap),
    .cap_val (cap_val),
    .cap_vld (cap_vld)
`endif
  );

  always #5 clki = ~clki;

  task automatic model_reset();
    m_count = 0; m_pcnt = 0; m_st = 0; m_tc = 1'b0; m_ovf = 1'b0;
`ifdef PROG_CNT_CAPTURE_EN
    m_cap_val = 0; m_cap_vld = 1'b0;
`endif
  endtask

  // One clock of the counter's rules, applied to the inputs present at the edge
  task automatic model_clk();
    logic running, tick, term;
    int   nst;
    running = (m_st == 1) && en && !clr && !load;
    tick    = running && (m_pcnt == int'(presc));
    nst     = m_st;
    m_tc    = 1'b0;
`ifdef PROG_CNT_CAPTURE_EN
    m_cap_vld = cap;
    if (cap) m_cap_val = m_count;
`endif
    if (clr) begin
      m_count = 0; m_ovf = 1'b0; m_pcnt = 0; nst = 0;
    end else begin
      if (m_st == 0 && en) nst = 1;
      if (m_st == 1 && !en) nst = 0;
      if (m_st == 2 && load && en) nst = 1;
      if (load) begin
        m_count = int'(load_val);
      end else if (tick) begin
        term = dir ? (m_count >= int'(modulus)) : (m_count == 0);
        if (!term) begin
          m_count = dir ? (m_count + 1) % MAXV : (m_count + MAXV - 1) % MAXV;
        end else if (mode == 2'b01) begin
          m_tc = !m_ovf; m_ovf = 1'b1;
        end else if (mode == 2'b10) begin
          m_tc = 1'b1; m_ovf = 1'b1; nst = 2;
        end else begin
          m_count = dir ? 0 : int'(modulus); m_tc = 1'b1; m_ovf = 1'b1;
        end
      end
      m_pcnt = (!running || tick) ? 0 : (m_pcnt + 1) % PMAX;
    end
    m_st = nst;
  endtask

  // Advance one clock; leaves the bench at the following falling edge
  task automatic step();
    @(posedge clki);
    model_clk();
    @(negedge clki);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (count !== 8'h00 || tc !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_initial: count=%h tc=%b ovf=%b busy=%b, expected 00 0 0 0", count, tc, ovf, busy);
    end
    @(negedge clki);
    rstn_n = 1'b1;
    model_reset();
    mode = 2'b01; dir = 1'b1; modulus = 8'h10; presc = '0;
    load = 1'b1; load_val = 8'h37; en = 1'b1;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if (count !== 8'h37 || tc !== 1'b1 || ovf !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_precondition: count=%h tc=%b ovf=%b busy=%b, expected 37 1 1 1", count, tc, ovf, busy);
    end
    rstn_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 8'h00 || tc !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: count=%h tc=%b ovf=%b busy=%b, expected 00 0 0 0", count, tc, ovf, busy);
    end
    en = 1'b0;
    #1;
    rstn_n = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_wrap_up();
    int exp_seq[6] = '{1, 2, 3, 4, 5, 0};
    clr = 1'b1; step(); clr = 1'b0;
    mode = 2'b00; dir = 1'b1; modulus = 8'd5; presc = '0; en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (count !== W'(exp_seq[i]) || tc !== (i == 5)) begin
        n_errors++;
        $display("FAIL wrap_up tick %0d: count=%0d tc=%b, expected count=%0d tc=%b", i + 1, count, tc, exp_seq[i], (i == 5));
      end
    end
    n_checks++;
    if (ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_up_ovf: ovf=%b, expected 1", ovf);
    end
    $display("test_wrap_up done: count=%0d ovf=%b", count, ovf);
  endtask

  task automatic test_prescale();
    clr = 1'b1; step(); clr = 1'b0;
    mode = 2'b00; dir = 1'b1; modulus = 8'hFF; presc = 4'd3; en = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (count !== W'((i + 1) / 4)) begin
        n_errors++;
        $display("FAIL prescale cycle %0d: count=%0d, expected %0d", i, count, (i + 1) / 4);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (count !== 8'd3 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL prescale_freeze cycle %0d: count=%0d busy=%b, expected 3 0", i, count, busy);
      end
    end
    presc = '0;
    $display("test_prescale done: count=%0d", count);
  endtask

  task automatic test_sat_down();
    int exp_seq[6] = '{3, 2, 1, 0, 0, 0};
    int tc_seen = 0;
    clr = 1'b1; step(); clr = 1'b0;
    mode = 2'b01; dir = 1'b0; modulus = 8'd9; presc = '0; en = 1'b1;
    load = 1'b1; load_val = 8'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      load = 1'b0;
      if (tc === 1'b1) tc_seen++;
      n_checks++;
      if (count !== W'(exp_seq[i])) begin
        n_errors++;
        $display("FAIL sat_down step %0d: count=%0d, expected %0d", i, count, exp_seq[i]);
      end
    end
    n_checks++;
    if (tc_seen != 1 || ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_down_tc: tc pulses=%0d ovf=%b, expected 1 pulse ovf=1", tc_seen, ovf);
    end
    clr = 1'b1; step(); clr = 1'b0;
    n_checks++;
    if (count !== 8'd0 || ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_down_clr: count=%0d ovf=%b, expected 0 0", count, ovf);
    end
    $display("test_sat_down done: tc pulses=%0d", tc_seen);
  endtask

  task automatic test_oneshot();
    int exp_cnt[4]  = '{0, 1, 2, 2};
    int exp_tc[4]   = '{0, 0, 0, 1};
    int exp_busy[4] = '{1, 1, 1, 0};
    clr = 1'b1; step(); clr = 1'b0;
    mode = 2'b10; dir = 1'b1; modulus = 8'd2; presc = '0; en = 1'b1;
    load = 1'b1; load_val = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      load = 1'b0;
      n_checks++;
      if (count !== W'(exp_cnt[i]) || tc !== 1'(exp_tc[i]) || busy !== 1'(exp_busy[i])) begin
        n_errors++;
        $display("FAIL oneshot step %0d: count=%0d tc=%b busy=%b, expected %0d %0d %0d",
                 i, count, tc, busy, exp_cnt[i], exp_tc[i], exp_busy[i]);
      end
    end
    step();
    n_checks++;
    if (count !== 8'd2 || tc !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL oneshot_done: count=%0d tc=%b busy=%b, expected 2 0 0", count, tc, busy);
    end
    load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if (count !== 8'd1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL oneshot_restart: count=%0d busy=%b, expected 1 1", count, busy);
    end
    $display("test_oneshot done: count=%0d", count);
  endtask

  task automatic test_clr_load();
    en = 1'b0; load = 1'b1; load_val = 8'h21;
    step();
    clr = 1'b1; load = 1'b1; load_val = 8'hAA;
    step();
    clr = 1'b0; load = 1'b0;
    n_checks++;
    if (count !== 8'h00) begin
      n_errors++;
      $display("FAIL clr_load: count=%h, expected 00", count);
    end
`ifdef PROG_CNT_CAPTURE_EN
    load = 1'b1; load_val = 8'd4;
    step();
    load = 1'b0; cap = 1'b1;
    step();
    cap = 1'b0;
    n_checks++;
    if (cap_val !== 8'd4 || cap_vld !== 1'b1) begin
      n_errors++;
      $display("FAIL capture: cap_val=%0d cap_vld=%b, expected 4 1", cap_val, cap_vld);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++;
    if (cap_val !== 8'd4 || cap_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL capture_after: cap_val=%0d cap_vld=%b, expected 4 0", cap_val, cap_vld);
    end
`endif
    $display("test_clr_load done: count=%h", count);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        mode    = 2'($urandom_range(0, 3));
        dir     = 1'($urandom_range(0, 1));
        modulus = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 24));
      end
      if ($urandom_range(0, 30) == 0) presc = PW'($urandom_range(0, PMAX - 1));
      clr      = ($urandom_range(0, 80) == 0);
      load     = ($urandom_range(0, 20) == 0);
      load_val = W'($urandom_range(0, 30));
      en       = ($urandom_range(0, 15) != 0);
`ifdef PROG_CNT_CAPTURE_EN
      cap      = ($urandom_range(0, 10) == 0);
`endif
      step();
      n_checks++;
      if (count !== W'(m_count) || tc !== m_tc || ovf !== m_ovf || busy !== (m_st == 1)) begin
        n_errors++;
        bad++;
        $display("FAIL random cycle %0d: count=%0d tc=%b ovf=%b busy=%b, expected %0d %b %b %b",
                 i, count, tc, ovf, busy, m_count, m_tc, m_ovf, (m_st == 1));
      end
`ifdef PROG_CNT_CAPTURE_EN
      n_checks++;
      if (cap_val !== W'(m_cap_val) || cap_vld !== m_cap_vld) begin
        n_errors++;
        bad++;
        $display("FAIL random_cap cycle %0d: cap_val=%0d cap_vld=%b, expected %0d %b",
                 i, cap_val, cap_vld, m_cap_val, m_cap_vld);
      end
`endif
    end
    clr = 1'b0; load = 1'b0; en = 1'b0;
`ifdef PROG_CNT_CAPTURE_EN
    cap = 1'b0;
`endif
    $display("test_random done: 3000 cycles, %0d mismatching cycles", bad);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap_up();
    test_prescale();
    test_sat_down();
    test_oneshot();
    test_clr_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
